// File: rtl/crc_pkg.sv
// Shared CRC-8 definitions used by the frame generator and the frame checker.
//   crc8_next : one-byte CRC-8 update, MSB-first, no reflection, no final XOR
//   state_t   : checker frame state (IDLE, PAYLOAD)
//   CRC_W     : CRC register width
//   CNT_W     : payload byte counter width
package crc_pkg;

    localparam int CRC_W = 8;
    localparam int CNT_W = 16;

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    function automatic logic [CRC_W-1:0] crc8_next(
        input logic [CRC_W-1:0] crc,
        input logic [7:0]       data,
        input logic [CRC_W-1:0] poly
    );
        logic [CRC_W-1:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[CRC_W-1] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_byte_update.sv
// Combinational CRC-8 byte update, one byte per cycle.
//   crc_in  : current CRC register value
//   data    : byte to fold in
//   crc_out : CRC register value after folding in data
module crc8_byte_update
    import crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = 8'h07
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);

    assign crc_out = crc8_next(crc_in, data, POLY);

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side CRC-8 frame checker. Each frame is payload bytes followed by
// one CRC byte flagged with last. Payload is forwarded, the CRC byte is
// dropped, and per-frame status is pulsed at frame end.
//   clk, reset             : clock (rising edge), async active-low reset
//   data, valid, last      : input byte stream, last marks the CRC byte
//   out_data, out_valid    : forwarded payload bytes (up to MAX_LEN per frame)
//   frame_done             : one-cycle frame-end pulse
//   crc_ok, crc_err        : frame status pulses (complementary)
//   len_err                : payload exceeded MAX_LEN
//   frame_len, crc_calc    : length and computed CRC of last completed frame
//   err_count              : saturating count of frames with crc_err
module crc_frame_checker
    import crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY    = 8'h07,
    parameter logic [CRC_W-1:0] INIT    = 8'h00,
    parameter int               MAX_LEN = 1500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data,
    input  logic             valid,
    input  logic             last,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             frame_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             len_err,
    output logic [CNT_W-1:0] frame_len,
    output logic [CRC_W-1:0] crc_calc,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
    localparam logic             FWD_FIRST = (MAX_LEN >= 1);

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d, crc_upd;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ovl_q, ovl_d;

    logic [7:0]       out_data_d;
    logic             out_valid_d, frame_done_d, crc_ok_d, crc_err_d, len_err_d;
    logic [CNT_W-1:0] frame_len_d, err_count_d;
    logic [CRC_W-1:0] crc_calc_d;

    logic             end_frame, match, lerr, ok;
    logic [CNT_W-1:0] end_len;
    logic [CRC_W-1:0] end_crc;

    // In IDLE crc_q already holds INIT, so one update path serves both states.
    crc8_byte_update #(.POLY(POLY)) u_update (
        .crc_in  (crc_q),
        .data    (data),
        .crc_out (crc_upd)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        ovl_d        = ovl_q;
        out_data_d   = out_data;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        crc_ok_d     = 1'b0;
        crc_err_d    = 1'b0;
        len_err_d    = 1'b0;
        frame_len_d  = frame_len;
        crc_calc_d   = crc_calc;
        err_count_d  = err_count;
        end_frame    = 1'b0;
        match        = 1'b0;
        lerr         = 1'b0;
        ok           = 1'b0;
        end_len      = '0;
        end_crc      = INIT;

        case (state_q)
            IDLE: begin
                if (valid) begin
                    if (last) begin
                        end_frame = 1'b1;
                        match     = (data == INIT);
                    end else begin
                        state_d = PAYLOAD;
                        crc_d   = crc_upd;
                        cnt_d   = CNT_W'(1);
                        if (FWD_FIRST) begin
                            out_data_d  = data;
                            out_valid_d = 1'b1;
                        end else begin
                            ovl_d = 1'b1;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (valid) begin
                    if (last) begin
                        end_frame = 1'b1;
                        match     = (data == crc_q);
                        lerr      = ovl_q;
                        end_len   = cnt_q;
                        end_crc   = crc_q;
                    end else begin
                        crc_d = crc_upd;
                        cnt_d = cnt_inc;
                        if (cnt_inc <= MAX_LEN_C) begin
                            out_data_d  = data;
                            out_valid_d = 1'b1;
                        end else begin
                            ovl_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (end_frame) begin
            ok           = match && !lerr;
            frame_done_d = 1'b1;
            crc_ok_d     = ok;
            crc_err_d    = !ok;
            len_err_d    = lerr;
            frame_len_d  = end_len;
            crc_calc_d   = end_crc;
            if (!ok && err_count != '1) begin
                err_count_d = err_count + 1'b1;
            end
            crc_d   = INIT;
            cnt_d   = '0;
            ovl_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            crc_q      <= INIT;
            cnt_q      <= '0;
            ovl_q      <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            frame_len  <= '0;
            crc_calc   <= '0;
            err_count  <= '0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            ovl_q      <= ovl_d;
            out_data   <= out_data_d;
            out_valid  <= out_valid_d;
            frame_done <= frame_done_d;
            crc_ok     <= crc_ok_d;
            crc_err    <= crc_err_d;
            len_err    <= len_err_d;
            frame_len  <= frame_len_d;
            crc_calc   <= crc_calc_d;
            err_count  <= err_count_d;
        end
    end

endmodule

// File: doc/crc_frame_checker.md
# crc_frame_checker

Receive-side CRC-8 frame checker, downstream of the CRC-8 generator. Takes a byte stream in which each frame is a payload followed by one CRC byte, marked by `last`. Forwards the payload bytes and drops the CRC byte. At frame end it reports pass/fail, payload length and an overlength flag, and keeps a saturating error counter. It is the receive-side counterpart that verifies what the generator produced.

## Interface
- `POLY`, 8'h07, CRC-8 generator polynomial (implicit x^8). Must match the generator.
- `INIT`, 8'h00, CRC register value at the start of every frame.
- `MAX_LEN`, 1500, maximum payload bytes. Larger frames are flagged overlength.
- `clk` input 1, single clock, rising edge.
- `reset` input 1, asynchronous, active-low. Clears all state and outputs.
- `data` input 8, stream byte.
- `valid` input 1, `data` is present this cycle. Gaps (valid=0) are allowed anywhere.
- `last` input 1, qualified by `valid`. This byte is the frame's CRC byte.
- `out_data` output 8, forwarded payload byte. Reset 8'h00.
- `out_valid` output 1, `out_data` is valid. Reset 0.
- `frame_done` output 1, one-cycle pulse at frame end. Reset 0.
- `crc_ok` output 1, pulse with `frame_done`: received CRC equals computed CRC and no overlength. Reset 0.
- `crc_err` output 1, pulse with `frame_done`: the exact complement of `crc_ok`. Reset 0.
- `len_err` output 1, pulse with `frame_done`: payload exceeded `MAX_LEN`. Reset 0.
- `frame_len` output 16, payload byte count of the last completed frame. Saturates at 16'hFFFF. Reset 0.
- `crc_calc` output 8, computed CRC of the last completed frame. Reset 8'h00.
- `err_count` output 16, number of frames with `crc_err`. Saturates at 16'hFFFF. Reset 0.

## Operation
- **CRC update:** MSB-first, no reflection, no final XOR. Per byte: `c = c ^ data`, then 8 iterations of `c = c[7] ? (c<<1)^POLY : c<<1`.
- **State machine:** IDLE, PAYLOAD.
  - IDLE: the CRC register holds `INIT` and the byte counter is 0.
  - IDLE + valid&!last: go to PAYLOAD. Fold in the byte, forward it, set count to 1.
  - IDLE + valid&last: zero-length frame. Compare `data` against `INIT`, pulse `frame_done`, stay in IDLE.
  - PAYLOAD + valid&!last: fold in the byte and increment the count.
  - Forwarding in PAYLOAD: forward the byte only while the count ≤ `MAX_LEN`. After that, set the internal overlength flag and swallow further bytes; CRC and count continue.
  - PAYLOAD + valid&last: compare `data` with the current CRC register (before any update with the CRC byte).
  - Frame end (both IDLE and PAYLOAD paths):
    - latch `frame_len` and `crc_calc`, and pulse `frame_done`, `crc_ok`/`crc_err` and `len_err`;
    - increment `err_count` on `crc_err`;
    - reload `INIT`, clear the count and the flag, and go to IDLE.
- **Overlength:** forces `crc_err`=1 even if the CRC matches.
- **CRC byte:** never appears on `out_data`.
- **Back-to-back frames:** a frame's first byte may arrive in the cycle right after the previous `last`. No idle cycle is needed.
- **Reset mid-frame:** the partial frame is discarded with no `frame_done`, and all outputs return to their reset values.

## Timing
- Latency: all outputs are registered.
- A payload byte accepted at edge n appears on `out_data`/`out_valid` from edge n+1 for one cycle.
- A `last` byte accepted at edge n causes `frame_done` and the status pulses for exactly one cycle after edge n+1.
- `frame_len` and `crc_calc` update at that same edge and hold until the next frame end.
- `out_valid` and `frame_done` are never high in the same cycle.
- There is no backpressure: the block accepts one byte per cycle indefinitely.

## Structure
- **Shared package `crc_pkg`:**
  - function `crc8_next(crc, data, poly)`, shared with the generator;
  - state enum `{IDLE, PAYLOAD}`;
  - localparams `CRC_W=8`, `CNT_W=16`.
- **Sub-module `crc8_byte_update`:** the single natural sub-module, purely combinational, one byte per cycle, wrapping `crc8_next`. Everything else stays in the top level.

## Test plan
- **Known vector:** payload "123456789" (31..39), then CRC byte F4 with `last` → nine bytes forwarded, `crc_ok`=1, `crc_calc`=F4, `frame_len`=9, `err_count`=0.
- **Good and bad frame:**
  - payload AB, CRC 58 → `crc_ok`=1, `frame_len`=1;
  - then payload AB, CRC 59 → `crc_err`=1, `crc_calc`=58, `err_count`=1.
- **Zero-length and gaps:**
  - lone `last` byte 00 → `frame_done`, `crc_ok`=1, `frame_len`=0;
  - then "123456789" with valid=0 gaps between bytes, CRC F4 → `crc_ok`=1, with the gaps reflected on `out_valid`.
- **Overlength:** with `MAX_LEN`=4, send 6 payload bytes and the correct CRC → only 4 bytes forwarded, `len_err`=1, `crc_err`=1, `frame_len`=6.
- **Back-to-back frames:** AB/58 then 01/07 on consecutive cycles → two `frame_done` pulses two cycles apart, both `crc_ok`.
- **Reset mid-frame:** send 3 payload bytes, then assert `reset`=0 asynchronously between edges → outputs clear immediately. After release, frame AB/58 → `crc_ok`=1, `frame_len`=1.
